prog_func_mux: RTL and testbench

PROG_FUNC_MUX -- requirements
Module: prog_func_mux

---
 rtl/prog_func_mux_pkg.sv | 31 +++
 rtl/prog_func_mux_mux4x1.sv | 10 +
 rtl/prog_func_mux.sv | 174 +++++++++++++++++
 tb/tb_prog_func_mux.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/prog_func_mux_pkg.sv
// Shared FSM state type, NVAR limits and lookup-tree geometry helpers.
package prog_func_mux_pkg;

  localparam int unsigned NVAR_MIN = 2;
  localparam int unsigned NVAR_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SWEEP = 2'd2
  } state_t;

  // Mux stages: one 4:1 per variable pair, plus a leading 2:1 for odd NVAR.
  function automatic int unsigned stg_num(input int unsigned nvar);
    return nvar / 2 + nvar % 2;
  endfunction

  // Select bits consumed once stage s has been applied (stage 0 is the table).
  function automatic int unsigned stg_bits(input int unsigned nvar, input int unsigned s);
    if (s == 0) return 0;
    if (nvar % 2 == 1) return 2 * s - 1;
    return 2 * s;
  endfunction

  // Lowest select bit used by stage s (s >= 1).
  function automatic int unsigned stg_lsb(input int unsigned nvar, input int unsigned s);
    if (nvar % 2 == 1) return (s == 1) ? 0 : 2 * s - 3;
    return 2 * (s - 1);
  endfunction

endpackage

// File: rtl/prog_func_mux_mux4x1.sv
// 4:1 mux leaf of the truth-table lookup tree.
module mux4x1 (
  input  logic [3:0] d,
  input  logic [1:0] s,
  output logic       y
);

  assign y = d[s];

endmodule

// File: rtl/prog_func_mux.sv
// Programmable NVAR-input boolean function: serial truth-table load, live
// registered lookup on sel, and an exhaustive sweep of all minterms.
module prog_func_mux
  import prog_func_mux_pkg::*;
#(
  parameter int unsigned NVAR  = 4,
  parameter int unsigned TBL_W = 2 ** NVAR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_ready,
  input  logic [NVAR-1:0] sel,
  output logic            y,
  input  logic            sweep_start,
  output logic            sweep_valid,
  output logic [NVAR-1:0] sweep_idx,
  output logic            sweep_y,
  output logic            sweep_done,
  output logic            busy,
  output logic            table_ok
);

  localparam int unsigned       NST  = stg_num(NVAR);
  localparam logic [NVAR-1:0]   LAST = NVAR'(TBL_W - 1);

  if (NVAR < NVAR_MIN || NVAR > NVAR_MAX) begin : g_bad_nvar
    $error("prog_func_mux: NVAR out of range");
  end

  state_t            state, state_nxt;
  logic [TBL_W-1:0]  act_tbl, act_d;
  logic [TBL_W-1:0]  shd_tbl, shd_d;
  logic [NVAR-1:0]   bit_cnt, bit_cnt_d;
  logic [NVAR-1:0]   sweep_idx_d;
  logic              sweep_valid_d, sweep_done_d, sweep_y_d;
  logic              cfg_ready_d, busy_d, table_ok_d, y_d;
  logic              look_sel, look_sweep;
  logic              accept, last_bit;

  assign accept   = cfg_valid & cfg_ready;
  assign last_bit = (bit_cnt == LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cfg_start)        state_nxt = ST_LOAD;
        else if (sweep_start) state_nxt = ST_SWEEP;
      end
      ST_LOAD:  if (accept && last_bit)  state_nxt = ST_IDLE;
      ST_SWEEP: if (sweep_idx == LAST)   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    cfg_ready_d   = (state_nxt == ST_LOAD);
    busy_d        = (state_nxt != ST_IDLE);
    sweep_valid_d = 1'b0;
    sweep_idx_d   = '0;
    sweep_done_d  = 1'b0;
    bit_cnt_d     = bit_cnt;
    shd_d         = shd_tbl;
    act_d         = act_tbl;
    table_ok_d    = table_ok;
    case (state)
      ST_IDLE: begin
        if (cfg_start) bit_cnt_d = '0;
        else if (sweep_start) sweep_valid_d = 1'b1;
      end
      ST_LOAD: begin
        if (accept) begin
          shd_d[bit_cnt] = cfg_bit;
          if (last_bit) begin
            act_d      = shd_d;
            table_ok_d = 1'b1;
            bit_cnt_d  = '0;
          end else begin
            bit_cnt_d  = bit_cnt + NVAR'(1);
          end
        end
      end
      ST_SWEEP: begin
        if (sweep_idx != LAST) begin
          sweep_valid_d = 1'b1;
          sweep_idx_d   = sweep_idx + NVAR'(1);
          sweep_done_d  = (sweep_idx_d == LAST);
        end
      end
      default: ;
    endcase
  end

  assign y_d       = look_sel;
  assign sweep_y_d = sweep_valid_d & look_sweep;

  // Registered outputs and tables
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_tbl     <= '0;
      shd_tbl     <= '0;
      bit_cnt     <= '0;
      table_ok    <= 1'b0;
      y           <= 1'b0;
      cfg_ready   <= 1'b0;
      busy        <= 1'b0;
      sweep_valid <= 1'b0;
      sweep_idx   <= '0;
      sweep_y     <= 1'b0;
      sweep_done  <= 1'b0;
    end else begin
      act_tbl     <= act_d;
      shd_tbl     <= shd_d;
      bit_cnt     <= bit_cnt_d;
      table_ok    <= table_ok_d;
      y           <= y_d;
      cfg_ready   <= cfg_ready_d;
      busy        <= busy_d;
      sweep_valid <= sweep_valid_d;
      sweep_idx   <= sweep_idx_d;
      sweep_y     <= sweep_y_d;
      sweep_done  <= sweep_done_d;
    end
  end

  // Two lookup trees over the active table: live sel and next sweep index.
  for (genvar p = 0; p < 2; p++) begin : g_look
    logic [NVAR-1:0] idx;
    if (p == 0) begin : g_idx_sel
      assign idx = sel;
    end else begin : g_idx_sweep
      assign idx = sweep_idx_d;
    end

    for (genvar s = 0; s <= NST; s++) begin : g_stg
      localparam int unsigned W = 1 << (NVAR - stg_bits(NVAR, s));
      logic [W-1:0] n;
      if (s == 0) begin : g_leaf
        assign n = act_tbl;
      end else if (NVAR % 2 == 1 && s == 1) begin : g_m2
        for (genvar j = 0; j < W; j++) begin : g_j
          assign n[j] = idx[0] ? g_stg[s-1].n[2*j+1] : g_stg[s-1].n[2*j];
        end
      end else begin : g_m4
        localparam int unsigned LSB = stg_lsb(NVAR, s);
        for (genvar j = 0; j < W; j++) begin : g_j
          mux4x1 u_mux (
            .d (g_stg[s-1].n[4*j +: 4]),
            .s (idx[LSB +: 2]),
            .y (n[j])
          );
        end
      end
    end

    if (p == 0) begin : g_out_sel
      assign look_sel = g_stg[NST].n[0];
    end else begin : g_out_sweep
      assign look_sweep = g_stg[NST].n[0];
    end
  end

endmodule

// File: tb/tb_prog_func_mux.sv
// Directed/randomized self-checking bench for prog_func_mux at NVAR=4.
module tb_prog_func_mux;

  localparam int unsigned NVAR  = 4;
  localparam int unsigned TBL_W = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_start = 1'b0, cfg_valid = 1'b0, cfg_bit = 1'b0;
  logic            cfg_ready;
  logic [NVAR-1:0] sel = '0;
  logic            y;
  logic            sweep_start = 1'b0;
  logic            sweep_valid, sweep_y, sweep_done, busy, table_ok;
  logic [NVAR-1:0] sweep_idx;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: active table as a plain 16-bit word plus the committed flag.
  logic [TBL_W-1:0] model_tbl = '0;
  logic             model_ok  = 1'b0;

  prog_func_mux #(.NVAR(NVAR)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_ready(cfg_ready), .sel(sel), .y(y),
    .sweep_start(sweep_start), .sweep_valid(sweep_valid),
    .sweep_idx(sweep_idx), .sweep_y(sweep_y), .sweep_done(sweep_done),
    .busy(busy), .table_ok(table_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; y must show the pre-edge table at the pre-edge sel.
  task automatic tick();
    logic exp_y;
    exp_y = model_tbl[sel];
    @(posedge clk);
    #1;
    check("y", 32'(y), 32'(exp_y));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_y"}, 32'(y), 0);
    check({tag, "_cfg_ready"}, 32'(cfg_ready), 0);
    check({tag, "_sweep_valid"}, 32'(sweep_valid), 0);
    check({tag, "_sweep_idx"}, 32'(sweep_idx), 0);
    check({tag, "_sweep_y"}, 32'(sweep_y), 0);
    check({tag, "_sweep_done"}, 32'(sweep_done), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_table_ok"}, 32'(table_ok), 0);
  endtask

  task automatic do_sweep(input bit parity);
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int i = 0; i < int'(TBL_W); i++) begin
      check("sweep_valid", 32'(sweep_valid), 1);
      check("sweep_idx", 32'(sweep_idx), 32'(i));
      check("sweep_y", 32'(sweep_y), 32'(model_tbl[i]));
      if (parity) check("sweep_parity", 32'(sweep_y), 32'($countones(i) & 1));
      check("sweep_done", 32'(sweep_done), 32'(i == int'(TBL_W) - 1));
      check("sweep_busy", 32'(busy), 1);
      check("sweep_table_ok", 32'(table_ok), 32'(model_ok));
      tick();
    end
    check("sweep_end_valid", 32'(sweep_valid), 0);
    check("sweep_end_done", 32'(sweep_done), 0);
    check("sweep_end_busy", 32'(busy), 0);
  endtask

  task automatic do_load(input logic [TBL_W-1:0] val, input bit gaps, input bit rnd_sel,
                         input bit collide);
    cfg_start   = 1'b1;
    sweep_start = collide;
    tick();
    cfg_start   = 1'b0;
    sweep_start = 1'b0;
    check("load_cfg_ready", 32'(cfg_ready), 1);
    check("load_busy", 32'(busy), 1);
    check("load_no_sweep", 32'(sweep_valid), 0);
    for (int k = 0; k < int'(TBL_W); k++) begin
      if (gaps) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          cfg_valid = 1'b0;
          cfg_bit   = 1'($urandom);
          if (rnd_sel) sel = NVAR'($urandom);
          tick();
          check("gap_cfg_ready", 32'(cfg_ready), 1);
          check("gap_table_ok", 32'(table_ok), 32'(model_ok));
        end
      end
      cfg_valid = 1'b1;
      cfg_bit   = val[k];
      if (rnd_sel) sel = NVAR'($urandom);
      if (collide && k == 0) sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      cfg_valid   = 1'b0;
      if (k < int'(TBL_W) - 1) begin
        check("bit_cfg_ready", 32'(cfg_ready), 1);
        check("bit_no_sweep", 32'(sweep_valid), 0);
        check("bit_table_ok", 32'(table_ok), 32'(model_ok));
      end
    end
    model_tbl = val;
    model_ok  = 1'b1;
    check("commit_cfg_ready", 32'(cfg_ready), 0);
    check("commit_table_ok", 32'(table_ok), 1);
    check("commit_busy", 32'(busy), 0);
  endtask

  initial begin
    bit seen7;
    // Reset state
    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("post_reset");

    // Sweep of the unloaded all-zero table
    do_sweep(1'b0);

    // Parity table, then live sel stepping every 5 cycles
    do_load(16'h6996, 1'b0, 1'b0, 1'b0);
    do_sweep(1'b1);
    for (int s = 0; s < int'(TBL_W); s++) begin
      sel = NVAR'(s);
      tick();
      check("sel_parity", 32'(y), 32'($countones(s) & 1));
      repeat (4) tick();
    end

    // All-ones load with gaps while sel wanders; old table holds until commit
    do_load(16'hFFFF, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      sel = NVAR'($urandom);
      tick();
      tick();
      check("all_ones_y", 32'(y), 1);
    end

    // Simultaneous starts: load wins, sweep_start ignored during load
    do_load(16'(($urandom)), 1'b1, 1'b1, 1'b1);
    do_sweep(1'b0);
    for (int r = 0; r < 2; r++) begin
      do_load(16'($urandom), 1'b1, 1'b1, 1'b0);
      do_sweep(1'b0);
    end

    // Reset in the middle of a sweep
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    seen7 = 1'b0;
    for (int i = 0; i < 20 && !seen7; i++) begin
      if (sweep_valid && sweep_idx == NVAR'(7)) seen7 = 1'b1;
      else tick();
    end
    check("sweep_reach7", 32'(seen7), 1);
    #2;
    rst = 1'b1;
    model_tbl = '0;
    model_ok  = 1'b0;
    #1;
    check_all_zero("mid_sweep_rst");
    tick();
    check_all_zero("rst_hold");
    rst = 1'b0;
    tick();
    check("rst_no_done", 32'(sweep_done), 0);
    do_sweep(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
